reset_sequencer: RTL and testbench

Staged reset release controller for the interferometer front end. It sits downstream of the board power-on reset generator and holds every datapath domain (ADC capture, DDS/reference, phase demodulator, host link) in reset until three conditions hold: power-on reset has completed, the PLL reports lock, and each earlier domain has acknowledged that it is ready. Stages are released one at a time with a settle delay before each, and each stage has a timeout. On a timeout the block retries a bounded number of times, then latches a fault.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/reset_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset release controller.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_POR,
    WAIT_LOCK,
    SETTLE,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  function automatic longint unsigned cyc(input longint unsigned us, input longint unsigned freq);
    return us * freq;
  endfunction

  function automatic int unsigned retry_width(input int unsigned max_retry);
    return (max_retry < 2) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; clears to 0 on user_rst.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         user_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge user_rst) begin
    if (user_rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: waits for POR and PLL lock, then releases each domain
// after a settle delay and waits for its ack, retrying on timeout up to a limit.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned FREQ           = 50,
  parameter int unsigned STAGE_DLY_US   = 100,
  parameter int unsigned ACK_TIMEOUT_US = 1000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned N              = 32,
  localparam int unsigned RW            = retry_width(MAX_RETRY)
) (
  input  logic                  clk,
  input  logic                  user_rst,
  input  logic                  por_done,
  input  logic                  pll_locked,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  seq_fault,
  output logic [2:0]            cur_stage,
  output logic [RW-1:0]         retry_cnt
);

  localparam longint unsigned DLY_CYC = cyc(STAGE_DLY_US, FREQ);
  localparam longint unsigned TO_CYC  = cyc(ACK_TIMEOUT_US, FREQ);
  localparam longint unsigned CNT_MAX = (64'd1 << N) - 64'd1;

  if (DLY_CYC == 0 || DLY_CYC > CNT_MAX) begin : g_dly_chk
    $error("reset_sequencer: settle delay does not fit the counter");
  end
  if (TO_CYC == 0 || TO_CYC > CNT_MAX) begin : g_to_chk
    $error("reset_sequencer: ack timeout does not fit the counter");
  end
  if (NUM_STAGES < 1 || NUM_STAGES > 8 || MAX_RETRY < 1) begin : g_par_chk
    $error("reset_sequencer: NUM_STAGES must be 1..8 and MAX_RETRY >= 1");
  end

  localparam logic [N-1:0] DLY_LAST = N'(DLY_CYC - 1);
  localparam logic [N-1:0] TO_LAST  = N'(TO_CYC - 1);

  state_t                  state_q, state_d;
  logic [N-1:0]            cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;
  logic [2:0]              cur_q, cur_d;
  logic [RW-1:0]           retry_q, retry_d, retry_inc;
  logic                    lock_s;
  logic [NUM_STAGES-1:0]   ack_s;
  logic [NUM_STAGES-1:0]   cur_bit;
  logic                    ack_sel;
  logic                    last_stage;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk      (clk),
    .user_rst (user_rst),
    .d        (pll_locked),
    .q        (lock_s)
  );

  sync_2ff #(.W(NUM_STAGES)) u_ack_sync (
    .clk      (clk),
    .user_rst (user_rst),
    .d        (stage_ack),
    .q        (ack_s)
  );

  // One-hot select avoids indexing a narrow vector with the 3-bit stage number.
  assign cur_bit    = NUM_STAGES'(1) << cur_q;
  assign ack_sel    = |(ack_s & cur_bit);
  assign last_stage = (cur_q == 3'(NUM_STAGES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_d     = rst_q;
    done_d    = done_q;
    fault_d   = fault_q;
    cur_d     = cur_q;
    retry_d   = retry_q;
    retry_inc = retry_q + RW'(1);

    unique case (state_q)
      WAIT_POR: begin
        rst_d   = '0;
        done_d  = 1'b0;
        cur_d   = '0;
        cnt_d   = '0;
        retry_d = '0;
        if (por_done) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        rst_d  = '0;
        done_d = 1'b0;
        cur_d  = '0;
        cnt_d  = '0;
        if (lock_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == DLY_LAST) begin
          rst_d   = rst_q | cur_bit;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_sel) begin
          cnt_d = '0;
          if (last_stage) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cur_d   = cur_q + 3'd1;
            state_d = SETTLE;
          end
        end else if (cnt_q == TO_LAST) begin
          rst_d   = '0;
          cnt_d   = '0;
          cur_d   = '0;
          retry_d = retry_inc;
          if (retry_inc == RW'(MAX_RETRY)) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            state_d = WAIT_LOCK;
          end
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      DONE: done_d = 1'b1;
      FAULT: begin
        rst_d   = '0;
        fault_d = 1'b1;
      end
      default: state_d = WAIT_POR;
    endcase

    // Higher-priority events override whatever the state case decided.
    if (!lock_s && (state_q inside {SETTLE, WAIT_ACK, DONE})) begin
      state_d = WAIT_LOCK;
      rst_d   = '0;
      done_d  = 1'b0;
      cur_d   = '0;
      cnt_d   = '0;
      retry_d = retry_q;
      fault_d = fault_q;
    end
    if (!por_done && state_q != FAULT) begin
      state_d = WAIT_POR;
      rst_d   = '0;
      done_d  = 1'b0;
      cur_d   = '0;
      cnt_d   = '0;
      retry_d = '0;
      fault_d = fault_q;
    end
  end

  always_ff @(posedge clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= WAIT_POR;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cur_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      cur_q   <= cur_d;
      retry_q <= retry_d;
    end
  end

  assign stage_rst_n = rst_q;
  assign seq_done    = done_q;
  assign seq_fault   = fault_q;
  assign cur_stage   = cur_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized lock/por/ack
// activity, checked every cycle against a deadline-based behavioural model.
module tb_reset_sequencer;

  localparam int NS  = 3;
  localparam int DLY = 4;
  localparam int TO  = 10;
  localparam int MR  = 2;

  localparam int M_POR  = 0;
  localparam int M_LOCK = 1;
  localparam int M_SET  = 2;
  localparam int M_ACK  = 3;
  localparam int M_DONE = 4;
  localparam int M_FLT  = 5;

  logic          clk = 1'b0;
  logic          user_rst;
  logic          por_done;
  logic          pll_locked;
  logic [NS-1:0] stage_ack;
  logic [NS-1:0] stage_rst_n;
  logic          seq_done;
  logic          seq_fault;
  logic [2:0]    cur_stage;
  logic [1:0]    retry_cnt;

  reset_sequencer #(
    .NUM_STAGES     (NS),
    .FREQ           (1),
    .STAGE_DLY_US   (DLY),
    .ACK_TIMEOUT_US (TO),
    .MAX_RETRY      (MR),
    .N              (32)
  ) dut (
    .clk         (clk),
    .user_rst    (user_rst),
    .por_done    (por_done),
    .pll_locked  (pll_locked),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done),
    .seq_fault   (seq_fault),
    .cur_stage   (cur_stage),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: phase flags, released/acked stage counts and an absolute deadline.
  bit          m_fault, m_por, m_seq;
  int          n_rel, n_acked, t_evt, retries;
  logic        lh [2];
  logic [NS-1:0] ah [2];
  int          rel_time [NS];
  int          ack_dly [NS];
  bit          withhold [NS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int model_mode();
    if (m_fault)          return M_FLT;
    if (!m_por)           return M_POR;
    if (!m_seq)           return M_LOCK;
    if (n_acked == NS)    return M_DONE;
    if (n_rel > n_acked)  return M_ACK;
    return M_SET;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_por = 0; m_seq = 0;
    n_rel = 0; n_acked = 0; t_evt = 0; retries = 0;
    lh[0] = 1'b0; lh[1] = 1'b0;
    ah[0] = '0;   ah[1] = '0;
  endtask

  task automatic model_step();
    logic          lock_s;
    logic [NS-1:0] ack_s;
    lock_s = lh[1];
    ack_s  = ah[1];
    lh[1] = lh[0]; lh[0] = pll_locked;
    ah[1] = ah[0]; ah[0] = stage_ack;
    if (m_fault) return;
    if (!por_done) begin
      m_por = 0; m_seq = 0; n_rel = 0; n_acked = 0; retries = 0;
      return;
    end
    if (!m_por) begin
      m_por = 1;
      return;
    end
    if (!m_seq) begin
      if (lock_s) begin
        m_seq = 1; n_rel = 0; n_acked = 0; t_evt = cyc + DLY;
      end
      return;
    end
    if (!lock_s) begin
      m_seq = 0; n_rel = 0; n_acked = 0;
      return;
    end
    if (n_acked == NS) return;
    if (n_rel == n_acked) begin
      if (cyc == t_evt) begin
        rel_time[n_rel] = cyc;
        n_rel++;
        t_evt = cyc + TO;
      end
      return;
    end
    if (ack_s[n_acked]) begin
      n_acked++;
      if (n_acked < NS) t_evt = cyc + DLY;
      return;
    end
    if (cyc == t_evt) begin
      n_rel = 0; n_acked = 0; m_seq = 0;
      retries++;
      if (retries == MR) m_fault = 1;
    end
  endtask

  task automatic check_all();
    int rst_exp, cur_exp, done_exp;
    rst_exp  = (1 << n_rel) - 1;
    done_exp = (m_seq && n_acked == NS) ? 1 : 0;
    cur_exp  = !m_seq ? 0 : (n_acked == NS ? NS - 1 : n_acked);
    chk("stage_rst_n", 32'(stage_rst_n), 32'(rst_exp));
    chk("seq_done",    32'(seq_done),    32'(done_exp));
    chk("seq_fault",   32'(seq_fault),   32'(m_fault));
    chk("cur_stage",   32'(cur_stage),   32'(cur_exp));
    chk("retry_cnt",   32'(retry_cnt),   32'(retries));
  endtask

  // Environment: each released stage acks ack_dly cycles after release unless withheld.
  task automatic drive_env();
    logic [NS-1:0] a;
    a = '0;
    for (int k = 0; k < NS; k++)
      if (!withhold[k] && n_rel > k && (cyc - rel_time[k]) >= ack_dly[k]) a[k] = 1'b1;
    stage_ack = a;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (user_rst) model_reset();
    else          model_step();
    @(negedge clk);
    check_all();
    drive_env();
  endtask

  task automatic do_reset(input int cycles);
    user_rst = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (cycles) tick();
    user_rst = 1'b0;
  endtask

  task automatic wait_mode(input string tag, input int want, input int stage, input int budget);
    int k;
    k = 0;
    while (!(model_mode() == want && (stage < 0 || n_acked == stage)) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) chk({"wait_", tag}, 32'(model_mode()), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    user_rst = 1'b1; por_done = 1'b0; pll_locked = 1'b0; stage_ack = '0;
    for (int k = 0; k < NS; k++) begin ack_dly[k] = 1; withhold[k] = 0; rel_time[k] = 0; end
    model_reset();
    @(negedge clk);
    do_reset(3);
    chk("reset_rst_n", 32'(stage_rst_n), 32'd0);
    chk("reset_retry", 32'(retry_cnt), 32'd0);

    // Nominal release 001 -> 011 -> 111.
    por_done = 1'b1; pll_locked = 1'b1;
    wait_mode("nominal", M_DONE, -1, 100);
    chk("nom_rst_n", 32'(stage_rst_n), 32'b111);
    chk("nom_done",  32'(seq_done),    32'd1);
    chk("nom_retry", 32'(retry_cnt),   32'd0);

    // Lock loss in DONE, then full re-sequence.
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("ll_rst_n", 32'(stage_rst_n), 32'd0);
    chk("ll_done",  32'(seq_done),    32'd0);
    pll_locked = 1'b1;
    wait_mode("relock", M_DONE, -1, 100);
    chk("relock_retry", 32'(retry_cnt), 32'd0);

    // Timeout on stage 1, twice -> fault.
    pll_locked = 1'b0; repeat (3) tick(); pll_locked = 1'b1;
    withhold[1] = 1;
    wait_mode("to_ack1", M_ACK, 1, 100);
    repeat (TO - 1) tick();
    chk("to_pre_rst_n", 32'(stage_rst_n), 32'b011);
    tick();
    chk("to_rst_n",  32'(stage_rst_n), 32'd0);
    chk("to_retry1", 32'(retry_cnt),   32'd1);
    wait_mode("fault", M_FLT, -1, 200);
    chk("flt_fault", 32'(seq_fault), 32'd1);
    chk("flt_retry", 32'(retry_cnt), 32'd2);
    por_done = 1'b0;
    repeat (5) tick();
    por_done = 1'b1;
    repeat (15) tick();
    chk("flt_sticky", 32'(seq_fault), 32'd1);
    withhold[1] = 0;
    do_reset(2);

    // Ack landing exactly on the timeout edge wins.
    ack_dly[0] = TO - 3;
    wait_mode("ack_on_to", M_DONE, -1, 200);
    chk("ack_on_to_retry", 32'(retry_cnt), 32'd0);
    ack_dly[0] = 1;

    // Ack and lock loss synchronized on the same edge: lock loss wins.
    pll_locked = 1'b0; repeat (3) tick(); pll_locked = 1'b1;
    withhold[1] = 1;
    wait_mode("sim_ack1", M_ACK, 1, 100);
    repeat (3) tick();
    withhold[1] = 0; ack_dly[1] = 0;
    drive_env();
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("sim_rst_n", 32'(stage_rst_n), 32'd0);
    chk("sim_cur",   32'(cur_stage),   32'd0);
    chk("sim_done",  32'(seq_done),    32'd0);
    ack_dly[1] = 1;
    pll_locked = 1'b1;

    // user_rst during SETTLE of stage 2.
    wait_mode("set2", M_SET, 2, 100);
    tick();
    user_rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_n",  32'(stage_rst_n), 32'd0);
    chk("mid_cur",    32'(cur_stage),   32'd0);
    chk("mid_retry",  32'(retry_cnt),   32'd0);
    chk("mid_done",   32'(seq_done),    32'd0);
    repeat (2) tick();
    user_rst = 1'b0;

    // por_done falling in WAIT_ACK clears retry_cnt.
    withhold[0] = 1;
    wait_mode("por_ack0", M_ACK, 0, 100);
    repeat (TO) tick();
    chk("por_retry1", 32'(retry_cnt), 32'd1);
    withhold[0] = 0;
    wait_mode("por_ack1", M_ACK, 1, 100);
    por_done = 1'b0;
    tick();
    chk("por_retry0", 32'(retry_cnt),   32'd0);
    chk("por_rst_n",  32'(stage_rst_n), 32'd0);
    por_done = 1'b1;

    // Randomized activity.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NS; k++) begin
        ack_dly[k]  = $urandom_range(0, 9);
        withhold[k] = ($urandom_range(0, 5) == 0);
      end
      for (int c = 0; c < 150; c++) begin
        tick();
        if (model_mode() == M_FLT && $urandom_range(0, 9) == 0) do_reset(2);
        else if ($urandom_range(0, 299) == 0) do_reset(1);
        if (pll_locked ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0))
          pll_locked = ~pll_locked;
        por_done = ($urandom_range(0, 199) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
